// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer helpers for the single-clock FIFO family.
package sync_fifo_pkg;

  localparam string MODE_FWFT = "FWFT";
  localparam string MODE_STD  = "STD";

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Distance between two pointers that carry one wrap bit above the address.
  function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                           input int unsigned pw);
    return (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage with a one-cycle registered read port.
module sync_fifo_ram #(
  parameter int  WIDTH = 33,
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the FIFO output register, so it must clear.
  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_pkt_fifo.sv
// Store-and-forward packet FIFO: the read side only ever sees committed packets.
module sync_pkt_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH       = 32,
  parameter int    DEPTH            = 64,
  parameter string MODE             = "FWFT",
  parameter int    PROG_FULL_THRESH = 48,
  parameter int    MAX_PKTS         = 16,
  localparam int   PW               = ptr_width(DEPTH),
  localparam int   CW               = $clog2(MAX_PKTS) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  full,
  output logic                  prog_full,
  output logic [PW-1:0]         wr_data_count,
  output logic                  pkt_dropped,
  input  logic                  rd_en,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_last,
  output logic                  empty,
  output logic [PW-1:0]         rd_data_count,
  output logic [CW-1:0]         pkt_count
);

  localparam int              AW         = PW - 1;
  localparam bit              IS_FWFT    = (MODE == MODE_FWFT);
  localparam logic [PW-1:0]   DEPTH_C    = PW'(DEPTH);
  localparam logic [CW-1:0]   MAX_PKTS_C = CW'(MAX_PKTS);

  logic [PW-1:0]     wr_ptr, cmt_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]     pkt_cnt;
  logic              bad, valid_q, dropped_q, prog_full_q;
  logic              accept, commit, abort, set_bad;
  logic              pop, load, pkt_dec, valid_nxt;
  logic [AW-1:0]     raddr;
  logic [DATA_WIDTH:0] ram_q;
  int unsigned       wr_cnt_nxt;

  assign wr_data_count = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
  assign rd_data_count = PW'(ptr_diff(32'(cmt_ptr), 32'(rd_ptr), PW));
  assign full          = (wr_data_count == DEPTH_C) || (pkt_cnt == MAX_PKTS_C);
  assign pkt_count     = pkt_cnt;

  // Write side: overflow poisons the rest of the packet until its last word.
  assign accept  = wr_en & ~full & ~wr_drop & ~bad;
  assign commit  = accept & wr_last;
  assign abort   = wr_drop | (wr_en & wr_last & (bad | full));
  assign set_bad = wr_en & ~wr_last & ~wr_drop & full;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (abort)       wr_ptr_nxt = cmt_ptr;
    else if (accept) wr_ptr_nxt = wr_ptr + PW'(1);
  end

  // Read side works only from cmt_ptr, never from the speculative wr_ptr.
  generate
    if (IS_FWFT) begin : g_fwft
      assign pop       = rd_en & valid_q;
      assign load      = (~valid_q | pop) & (rd_data_count != PW'(valid_q));
      assign raddr     = rd_ptr[AW-1:0] + AW'(valid_q);
      assign pkt_dec   = pop & ram_q[DATA_WIDTH];
      assign valid_nxt = load | (valid_q & ~pop);
      assign empty     = ~valid_q;
    end else begin : g_std
      assign empty     = (rd_data_count == '0);
      assign pop       = rd_en & ~empty;
      assign load      = pop;
      assign raddr     = rd_ptr[AW-1:0];
      assign pkt_dec   = valid_q & ram_q[DATA_WIDTH];
      assign valid_nxt = pop;
    end
  endgenerate

  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign wr_cnt_nxt = ptr_diff(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PW);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      pkt_cnt     <= '0;
      bad         <= 1'b0;
      valid_q     <= 1'b0;
      dropped_q   <= 1'b0;
      prog_full_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      if (commit) cmt_ptr <= wr_ptr + PW'(1);
      pkt_cnt     <= pkt_cnt + CW'(commit) - CW'(pkt_dec);
      bad         <= abort ? 1'b0 : (bad | set_bad);
      valid_q     <= valid_nxt;
      dropped_q   <= abort & (wr_en | (wr_ptr != cmt_ptr));
      prog_full_q <= wr_cnt_nxt >= unsigned'(PROG_FULL_THRESH);
    end
  end

  sync_fifo_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (accept),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_last, din}),
    .re    (load),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign valid       = valid_q;
  assign dout        = ram_q[DATA_WIDTH-1:0];
  assign rd_last     = ram_q[DATA_WIDTH];
  assign pkt_dropped = dropped_q;
  assign prog_full   = prog_full_q;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Bench for sync_pkt_fifo: FWFT and STD instances against a queue-based packet model.
module tb_sync_pkt_fifo;

  localparam int DW = 32, DEPTH = 16, THRESH = 12, MAXP = 16;
  localparam int PW = 5, CW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          wr_en, wr_last, wr_drop, rd_en;
  logic [DW-1:0] din, dout;
  logic          full, prog_full, pkt_dropped, valid, rd_last, empty;
  logic [PW-1:0] wr_data_count, rd_data_count;
  logic [CW-1:0] pkt_count;

  logic          s_wr_en, s_wr_last, s_wr_drop, s_rd_en;
  logic [DW-1:0] s_din, s_dout;
  logic          s_full, s_prog_full, s_pkt_dropped, s_valid, s_rd_last, s_empty;
  logic [PW-1:0] s_wr_data_count, s_rd_data_count;
  logic [CW-1:0] s_pkt_count;

  sync_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE("FWFT"),
                  .PROG_FULL_THRESH(THRESH), .MAX_PKTS(MAXP)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din), .wr_last(wr_last),
    .wr_drop(wr_drop), .full(full), .prog_full(prog_full), .wr_data_count(wr_data_count),
    .pkt_dropped(pkt_dropped), .rd_en(rd_en), .valid(valid), .dout(dout), .rd_last(rd_last),
    .empty(empty), .rd_data_count(rd_data_count), .pkt_count(pkt_count));

  sync_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE("STD"),
                  .PROG_FULL_THRESH(THRESH), .MAX_PKTS(MAXP)) dut_std (
    .clock(clock), .reset(reset), .wr_en(s_wr_en), .din(s_din), .wr_last(s_wr_last),
    .wr_drop(s_wr_drop), .full(s_full), .prog_full(s_prog_full),
    .wr_data_count(s_wr_data_count), .pkt_dropped(s_pkt_dropped), .rd_en(s_rd_en),
    .valid(s_valid), .dout(s_dout), .rd_last(s_rd_last), .empty(s_empty),
    .rd_data_count(s_rd_data_count), .pkt_count(s_pkt_count));

  // Reference model: committed words and the open packet, each entry {last, data}.
  logic [DW:0]   cq[$], pend[$], scq[$], spend[$];
  int            pk;
  bit            bad_m, valid_m, drop_m, svalid_m, sdrop_m;
  logic [DW-1:0] dout_m;
  logic          last_m;
  logic [DW:0]   sdout_m;
  int            vectors = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fwft();
    int wc = cq.size() + pend.size();
    chk("valid",         64'(valid),         64'(valid_m));
    chk("empty",         64'(empty),         64'(!valid_m));
    chk("wr_data_count", 64'(wr_data_count), 64'(wc));
    chk("rd_data_count", 64'(rd_data_count), 64'(cq.size()));
    chk("pkt_count",     64'(pkt_count),     64'(pk));
    chk("pkt_dropped",   64'(pkt_dropped),   64'(drop_m));
    chk("full",          64'(full),          64'((wc == DEPTH) || (pk == MAXP)));
    chk("prog_full",     64'(prog_full),     64'(wc >= THRESH));
    chk("dout",          64'(dout),          64'(dout_m));
    chk("rd_last",       64'(rd_last),       64'(last_m));
  endtask

  task automatic check_std();
    chk("s_valid",         64'(s_valid),         64'(svalid_m));
    chk("s_empty",         64'(s_empty),         64'(scq.size() == 0));
    chk("s_rd_data_count", 64'(s_rd_data_count), 64'(scq.size()));
    chk("s_wr_data_count", 64'(s_wr_data_count), 64'(scq.size() + spend.size()));
    chk("s_pkt_dropped",   64'(s_pkt_dropped),   64'(sdrop_m));
    chk("s_dout",          64'(s_dout),          64'(sdout_m[DW-1:0]));
    chk("s_rd_last",       64'(s_rd_last),       64'(sdout_m[DW]));
  endtask

  task automatic idle_inputs();
    wr_en = 0; din = '0; wr_last = 0; wr_drop = 0; rd_en = 0;
    s_wr_en = 0; s_din = '0; s_wr_last = 0; s_wr_drop = 0; s_rd_en = 0;
  endtask

  task automatic step(input bit we, input logic [DW-1:0] d, input bit l,
                      input bit dr, input bit re);
    int  n_pre;
    bit  full_pre, pop;
    n_pre    = cq.size();
    full_pre = ((cq.size() + pend.size()) == DEPTH) || (pk == MAXP);
    pop      = re && valid_m;
    wr_en = we; din = d; wr_last = l; wr_drop = dr; rd_en = re;
    @(posedge clock);
    drop_m = 1'b0;
    if (pop) begin
      if (cq[0][DW]) pk--;
      void'(cq.pop_front());
      valid_m = (n_pre >= 2);
    end else if (!valid_m) begin
      valid_m = (n_pre >= 1);
    end
    if (dr) begin
      drop_m = (pend.size() > 0) || we;
      pend.delete();
      bad_m = 1'b0;
    end else if (we) begin
      if (bad_m || full_pre) begin
        if (l) begin
          drop_m = 1'b1;
          pend.delete();
          bad_m = 1'b0;
        end else begin
          bad_m = 1'b1;
        end
      end else begin
        pend.push_back({l, d});
        if (l) begin
          foreach (pend[i]) cq.push_back(pend[i]);
          pend.delete();
          pk++;
        end
      end
    end
    if (valid_m) begin
      dout_m = cq[0][DW-1:0];
      last_m = cq[0][DW];
    end
    #1;
    idle_inputs();
    check_fwft();
  endtask

  task automatic step_std(input bit we, input logic [DW-1:0] d, input bit l,
                          input bit dr, input bit re);
    bit pop;
    pop = re && (scq.size() > 0);
    s_wr_en = we; s_din = d; s_wr_last = l; s_wr_drop = dr; s_rd_en = re;
    @(posedge clock);
    svalid_m = pop;
    sdrop_m  = 1'b0;
    if (pop) begin
      sdout_m = scq[0];
      void'(scq.pop_front());
    end
    if (dr) begin
      sdrop_m = (spend.size() > 0) || we;
      spend.delete();
    end else if (we) begin
      spend.push_back({l, d});
      if (l) begin
        foreach (spend[i]) scq.push_back(spend[i]);
        spend.delete();
      end
    end
    #1;
    idle_inputs();
    check_std();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    wr_en = 1'b1; din = '1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
    cq.delete(); pend.delete(); scq.delete(); spend.delete();
    pk = 0; bad_m = 0; valid_m = 0; drop_m = 0; dout_m = '0; last_m = 0;
    svalid_m = 0; sdrop_m = 0; sdout_m = '0;
    check_fwft();
    check_std();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // 4-word packet, no reads, then read back
    for (int i = 0; i < 4; i++) step(1, 32'h10 + i, i == 3, 0, 0);
    chk("t1_empty_at_commit", 64'(empty), 64'(1));
    step(0, '0, 0, 0, 0);
    chk("t1_valid_after_e1", 64'(valid), 64'(1));
    chk("t1_rd_count", 64'(rd_data_count), 64'(4));
    chk("t1_pkt_count", 64'(pkt_count), 64'(1));
    chk("t1_first_word", 64'(dout), 64'(32'h10));
    drain(4);
    chk("t1_last_word", 64'(dout), 64'(32'h13));

    // Abort with wr_drop, then a clean packet
    for (int i = 0; i < 3; i++) step(1, 32'h50 + i, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    chk("t2_drop_pulse", 64'(pkt_dropped), 64'(1));
    chk("t2_wr_count", 64'(wr_data_count), 64'(0));
    step(1, 32'hA0, 0, 0, 0);
    step(1, 32'hA1, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    drain(3);

    // Overflow on the word after a nearly-full commit
    for (int i = 0; i < 15; i++) step(1, 32'h100 + i, i == 14, 0, 0);
    step(1, 32'h200, 0, 0, 0);
    chk("t3_full", 64'(full), 64'(1));
    step(1, 32'h201, 1, 0, 0);
    chk("t3_drop_pulse", 64'(pkt_dropped), 64'(1));
    chk("t3_wr_count", 64'(wr_data_count), 64'(15));
    drain(17);

    // Oversize packet is dropped on its last word
    for (int i = 0; i < 20; i++) step(1, 32'h300 + i, i == 19, 0, 0);
    chk("t4_drop_at_20", 64'(pkt_dropped), 64'(1));
    chk("t4_pkt_count", 64'(pkt_count), 64'(0));
    step(0, '0, 0, 0, 0);

    // Streaming 1-word packets with continuous reads
    for (int i = 0; i < 100; i++) begin
      step(1, 32'h1000 + i, 1, 0, 1);
      chk("t5_pkt_le2", 64'(pkt_count <= 2), 64'(1));
    end
    drain(4);
    chk("t5_drained", 64'(rd_data_count), 64'(0));

    // Reset mid-packet, then mid-read
    for (int i = 0; i < 5; i++) step(1, 32'h400 + i, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h500 + i, i == 2, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    do_reset();
    step(1, 32'h600, 0, 0, 0);
    step(1, 32'h601, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    drain(3);

    // Randomized traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(99) < 70, $urandom(), $urandom_range(99) < 25,
           $urandom_range(99) < 3, $urandom_range(99) < 60);
    drain(20);

    // STD mode: streaming, then light random traffic
    do_reset();
    for (int i = 0; i < 30; i++) step_std(1, 32'h2000 + i, 1, 0, 1);
    for (int i = 0; i < 4; i++) step_std(0, '0, 0, 0, 1);
    for (int i = 0; i < 250; i++) begin
      bit room;
      room = (scq.size() + spend.size()) < 12;
      step_std(room && ($urandom_range(99) < 50), $urandom(), $urandom_range(99) < 30,
               $urandom_range(99) < 5, $urandom_range(99) < 50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
